// File: rtl/io_responder_if.sv
// CPU/operator side signals of the IN/OUT/HALT responder.
// master = CPU and operator panel, slave = responder.
interface io_responder_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int SWITCH_WIDTH = 18
);
   logic                    op_in;
   logic                    op_out;
   logic                    op_halt;
   logic [DATA_WIDTH-1:0]   cpu_data;
   logic [SWITCH_WIDTH-1:0] switches;
   logic                    button;
   logic [DATA_WIDTH-1:0]   in_data;
   logic                    in_valid;
   logic                    out_ack;
   logic [DATA_WIDTH-1:0]   display_value;
   logic                    display_valid;
   logic                    cpu_stall;
   logic                    halted;
   logic                    protocol_error;
   logic [2:0]              state_dbg;

   modport master (
      output op_in, op_out, op_halt, cpu_data, switches, button,
      input  in_data, in_valid, out_ack, display_value, display_valid,
             cpu_stall, halted, protocol_error, state_dbg
   );

   modport slave (
      input  op_in, op_out, op_halt, cpu_data, switches, button,
      output in_data, in_valid, out_ack, display_value, display_valid,
             cpu_stall, halted, protocol_error, state_dbg
   );
endinterface

// File: rtl/io_responder.sv
// Stalls the CPU on IN/OUT/HALT until an operator button edge; strobes land one cycle after the edge.
// The CPU is held by cpu_stall and releases each request by dropping its op_* level.
module io_responder #(
   parameter int DATA_WIDTH   = 32,
   parameter int SWITCH_WIDTH = 18,
   parameter int SIGN_EXTEND  = 0
) (
   input logic           clock,
   input logic           reset,
   io_responder_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_IN  = 3'd1,
      IN_DONE  = 3'd2,
      WAIT_OUT = 3'd3,
      OUT_DONE = 3'd4,
      HALTED   = 3'd5
   } state_t;

   state_t                state, next_state;
   logic                  button_q, press, any_op, multi_op;
   logic                  in_load, out_load, ack_set, disp_clr, err_set, stall;
   logic [DATA_WIDTH-1:0] ext_switches;
   logic [DATA_WIDTH-1:0] in_data_q, display_value_q;
   logic                  in_valid_q, out_ack_q, display_valid_q, halted_q, protocol_error_q;

   generate
      if (SIGN_EXTEND != 0 && SWITCH_WIDTH < DATA_WIDTH) begin : g_sext
         assign ext_switches = {{(DATA_WIDTH-SWITCH_WIDTH){bus.switches[SWITCH_WIDTH-1]}}, bus.switches};
      end else if (SWITCH_WIDTH < DATA_WIDTH) begin : g_zext
         assign ext_switches = {{(DATA_WIDTH-SWITCH_WIDTH){1'b0}}, bus.switches};
      end else begin : g_full
         assign ext_switches = bus.switches;
      end
   endgenerate

   // A button already high when a wait state is entered has button_q set, so it never counts.
   assign press    = bus.button & ~button_q;
   assign any_op   = bus.op_in | bus.op_out | bus.op_halt;
   assign multi_op = (bus.op_in & bus.op_out) | (bus.op_in & bus.op_halt) | (bus.op_out & bus.op_halt);

   always_comb begin
      next_state = state;
      in_load    = 1'b0;
      out_load   = 1'b0;
      ack_set    = 1'b0;
      disp_clr   = 1'b0;
      err_set    = 1'b0;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            stall   = any_op;
            err_set = multi_op;
            if (bus.op_halt) begin
               next_state = HALTED;
            end else if (bus.op_in) begin
               next_state = WAIT_IN;
            end else if (bus.op_out) begin
               next_state = WAIT_OUT;
               out_load   = 1'b1;
            end
         end
         WAIT_IN: begin
            stall = 1'b1;
            if (press) begin
               in_load    = 1'b1;
               next_state = IN_DONE;
            end else if (!bus.op_in) begin
               next_state = IDLE;
            end
         end
         IN_DONE: begin
            if (!bus.op_in) next_state = IDLE;
         end
         WAIT_OUT: begin
            stall = 1'b1;
            if (press) begin
               ack_set    = 1'b1;
               next_state = OUT_DONE;
            end else if (!bus.op_out) begin
               disp_clr   = 1'b1;
               next_state = IDLE;
            end
         end
         OUT_DONE: begin
            if (!bus.op_out) begin
               disp_clr   = 1'b1;
               next_state = IDLE;
            end
         end
         HALTED: begin
            stall = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         button_q         <= 1'b0;
         in_data_q        <= '0;
         in_valid_q       <= 1'b0;
         out_ack_q        <= 1'b0;
         display_value_q  <= '0;
         display_valid_q  <= 1'b0;
         halted_q         <= 1'b0;
         protocol_error_q <= 1'b0;
      end else begin
         state            <= next_state;
         button_q         <= bus.button;
         in_valid_q       <= in_load;
         out_ack_q        <= ack_set;
         halted_q         <= (next_state == HALTED);
         protocol_error_q <= protocol_error_q | err_set;
         if (in_load) in_data_q <= ext_switches;
         if (out_load) begin
            display_value_q <= bus.cpu_data;
            display_valid_q <= 1'b1;
         end else if (disp_clr) begin
            display_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_data        = in_data_q;
   assign bus.in_valid       = in_valid_q;
   assign bus.out_ack        = out_ack_q;
   assign bus.display_value  = display_value_q;
   assign bus.display_valid  = display_valid_q;
   assign bus.cpu_stall      = stall;
   assign bus.halted         = halted_q;
   assign bus.protocol_error = protocol_error_q;
   assign bus.state_dbg      = state;
endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed scenarios plus random IN/OUT transactions on a
// zero-extending and a sign-extending instance driven in lockstep.
module tb_io_responder;
   localparam int DW = 32;
   localparam int SW = 18;

   logic          clock = 1'b0;
   logic          reset;
   logic          op_in, op_out, op_halt, button;
   logic [DW-1:0] cpu_data;
   logic [SW-1:0] switches;

   int checks = 0, failures = 0;
   int n_in0 = 0, n_in1 = 0, n_ack0 = 0, n_ack1 = 0;
   int exp_nin = 0, exp_nack = 0;
   logic [DW-1:0] exp_in0 = '0, exp_in1 = '0, exp_disp = '0;

   always #5 clock = ~clock;

   io_responder_if #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW)) bus0 ();
   io_responder_if #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW)) bus1 ();

   assign bus0.op_in = op_in;       assign bus1.op_in = op_in;
   assign bus0.op_out = op_out;     assign bus1.op_out = op_out;
   assign bus0.op_halt = op_halt;   assign bus1.op_halt = op_halt;
   assign bus0.cpu_data = cpu_data; assign bus1.cpu_data = cpu_data;
   assign bus0.switches = switches; assign bus1.switches = switches;
   assign bus0.button = button;     assign bus1.button = button;

   io_responder #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .SIGN_EXTEND(0)) dut0 (
      .clock(clock), .reset(reset), .bus(bus0));
   io_responder #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW), .SIGN_EXTEND(1)) dut1 (
      .clock(clock), .reset(reset), .bus(bus1));

   // Strobe counters, sampled mid-cycle.
   always @(negedge clock) begin
      if (bus0.in_valid === 1'b1) n_in0++;
      if (bus1.in_valid === 1'b1) n_in1++;
      if (bus0.out_ack === 1'b1) n_ack0++;
      if (bus1.out_ack === 1'b1) n_ack1++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] extend(input logic [SW-1:0] s, input bit sext);
      if (sext && s >= 18'h20000) return 32'(s) + 32'hFFFC0000;
      return 32'(s);
   endfunction

   task automatic chk_counts(input string tag);
      chk({tag, "_nin0"}, n_in0, exp_nin);
      chk({tag, "_nin1"}, n_in1, exp_nin);
      chk({tag, "_nack0"}, n_ack0, exp_nack);
      chk({tag, "_nack1"}, n_ack1, exp_nack);
   endtask

   initial begin
      int kind, w;
      reset = 1'b1; op_in = 0; op_out = 0; op_halt = 0;
      button = 1'b1; switches = 18'h3FFFF; cpu_data = '0;
      cyc(2);
      chk("rst_in_data", bus0.in_data, 0);
      chk("rst_in_valid", bus0.in_valid, 0);
      chk("rst_out_ack", bus0.out_ack, 0);
      chk("rst_disp_val", bus0.display_value, 0);
      chk("rst_disp_vld", bus0.display_valid, 0);
      chk("rst_halted", bus0.halted, 0);
      chk("rst_perr", bus0.protocol_error, 0);
      chk("rst_state", bus0.state_dbg, 0);
      chk("rst_stall", bus0.cpu_stall, 0);
      chk("rst_in_data1", bus1.in_data, 0);

      // Button high across reset release: no strobe until a fresh edge.
      reset = 1'b0; op_in = 1'b1;
      cyc(1);
      chk("held_state", bus0.state_dbg, 1);
      chk("held_stall", bus0.cpu_stall, 1);
      cyc(3);
      chk_counts("held");
      button = 1'b0; cyc(2);
      chk("held_state2", bus0.state_dbg, 1);
      button = 1'b1; cyc(1);
      exp_in0 = extend(switches, 0); exp_in1 = extend(switches, 1); exp_nin++;
      chk("t1_in_valid", bus0.in_valid, 1);
      chk("t1_in_data0", bus0.in_data, exp_in0);
      chk("t1_in_data1", bus1.in_data, exp_in1);
      chk("t1_state", bus0.state_dbg, 2);
      chk("t1_stall", bus0.cpu_stall, 0);
      cyc(1);
      chk("t1_in_valid_off", bus0.in_valid, 0);
      button = 1'b0; op_in = 1'b0; cyc(1);
      chk("t1_idle", bus0.state_dbg, 0);
      chk("t1_hold_data", bus0.in_data, exp_in0);
      chk_counts("t1");

      // Zero/sign extension with held op_in after completion.
      switches = 18'h20005; op_in = 1'b1; cyc(2);
      button = 1'b1; cyc(1);
      exp_in0 = extend(switches, 0); exp_in1 = extend(switches, 1); exp_nin++;
      chk("t2_in_data0", bus0.in_data, 32'h00020005);
      chk("t2_in_data1", bus1.in_data, 32'hFFFE0005);
      cyc(2);
      button = 1'b0; cyc(1); button = 1'b1; cyc(1);
      chk("t2_state_done", bus0.state_dbg, 2);
      chk("t2_stall", bus0.cpu_stall, 0);
      op_in = 1'b0; button = 1'b0; cyc(1);
      chk("t2_idle", bus0.state_dbg, 0);
      chk_counts("t2");

      // OUT with cpu_data changing during the wait.
      op_out = 1'b1; cpu_data = 32'hDEADBEEF; cyc(1);
      exp_disp = 32'hDEADBEEF;
      chk("t3_state", bus0.state_dbg, 3);
      chk("t3_disp_vld", bus0.display_valid, 1);
      chk("t3_stall", bus0.cpu_stall, 1);
      cpu_data = '0; cyc(2);
      chk("t3_frozen", bus0.display_value, 32'hDEADBEEF);
      button = 1'b1; cyc(1);
      exp_nack++;
      chk("t3_ack", bus0.out_ack, 1);
      chk("t3_state_done", bus0.state_dbg, 4);
      chk("t3_stall_done", bus0.cpu_stall, 0);
      cyc(1);
      chk("t3_ack_off", bus0.out_ack, 0);
      chk("t3_disp_vld2", bus0.display_valid, 1);
      op_out = 1'b0; button = 1'b0; cyc(1);
      chk("t3_disp_blank", bus0.display_valid, 0);
      chk("t3_idle", bus0.state_dbg, 0);
      chk_counts("t3");

      // Button held across an entire IN request.
      button = 1'b1; cyc(1);
      op_in = 1'b1; cyc(3);
      chk("t5_state", bus0.state_dbg, 1);
      op_in = 1'b0; cyc(1);
      chk("t5_idle", bus0.state_dbg, 0);
      chk_counts("t5");
      button = 1'b0; cyc(1);

      // Random transactions against the transaction-level model.
      for (int t = 0; t < 40; t++) begin
         kind = int'($urandom_range(0, 3));
         w = int'($urandom_range(0, 3));
         if (kind < 2) begin
            switches = SW'($urandom); op_in = 1'b1; cyc(1);
            chk("r_in_stall", bus0.cpu_stall, 1);
            repeat (w) begin switches = SW'($urandom); cyc(1); end
            if (kind == 0) begin
               exp_in0 = extend(switches, 0); exp_in1 = extend(switches, 1); exp_nin++;
               button = 1'b1; cyc(2);
            end
            op_in = 1'b0; button = 1'b0; cyc(1);
         end else begin
            cpu_data = $urandom; op_out = 1'b1; cyc(1);
            exp_disp = cpu_data;
            chk("r_out_vld", bus0.display_valid, 1);
            repeat (w) begin cpu_data = $urandom; cyc(1); end
            if (kind == 2) begin
               exp_nack++;
               button = 1'b1; cyc(2);
            end
            op_out = 1'b0; button = 1'b0; cyc(1);
            chk("r_out_blank", bus0.display_valid, 0);
         end
         chk("r_state", bus0.state_dbg, 0);
         chk("r_in_data0", bus0.in_data, exp_in0);
         chk("r_in_data1", bus1.in_data, exp_in1);
         chk("r_disp_val", bus0.display_value, exp_disp);
         chk_counts("r");
      end
      chk("r_perr_clean", bus0.protocol_error, 0);

      // Two requests at once: IN wins, error is sticky.
      switches = 18'h0ABCD; op_in = 1'b1; op_out = 1'b1; cyc(1);
      chk("t7_state", bus0.state_dbg, 1);
      chk("t7_perr", bus0.protocol_error, 1);
      op_out = 1'b0; button = 1'b1; cyc(1);
      exp_in0 = extend(switches, 0); exp_in1 = extend(switches, 1); exp_nin++;
      chk("t7_in_data", bus0.in_data, exp_in0);
      cyc(1); op_in = 1'b0; button = 1'b0; cyc(1);
      op_out = 1'b1; cpu_data = 32'h000055AA; cyc(1);
      exp_disp = cpu_data;
      button = 1'b1; cyc(1); exp_nack++;
      cyc(1); op_out = 1'b0; button = 1'b0; cyc(1);
      chk("t7_perr_sticky", bus0.protocol_error, 1);
      chk("t7_idle", bus0.state_dbg, 0);
      chk_counts("t7");

      // HALT is absorbing until reset.
      op_halt = 1'b1; cyc(1);
      chk("t8_state", bus0.state_dbg, 5);
      chk("t8_halted", bus0.halted, 1);
      chk("t8_stall", bus0.cpu_stall, 1);
      op_halt = 1'b0; op_in = 1'b1; cyc(1);
      button = 1'b1; cyc(1); button = 1'b0; cyc(1); button = 1'b1; cyc(1);
      op_in = 1'b0; op_out = 1'b1; button = 1'b0; cyc(1); button = 1'b1; cyc(2);
      chk("t8_state2", bus0.state_dbg, 5);
      chk("t8_halted2", bus0.halted, 1);
      chk("t8_stall2", bus0.cpu_stall, 1);
      chk("t8_disp_val", bus0.display_value, exp_disp);
      chk_counts("t8");
      op_out = 1'b0; button = 1'b0;
      reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
      chk("t8_rst_state", bus0.state_dbg, 0);
      chk("t8_rst_halted", bus0.halted, 0);
      chk("t8_rst_perr", bus0.protocol_error, 0);
      chk("t8_rst_stall", bus0.cpu_stall, 0);

      // Reset in the middle of an OUT.
      op_out = 1'b1; cpu_data = 32'hCAFEF00D; cyc(1);
      chk("t9_disp_vld", bus0.display_valid, 1);
      reset = 1'b1; cyc(1);
      chk("t9_disp_vld_rst", bus0.display_valid, 0);
      chk("t9_disp_val_rst", bus0.display_value, 0);
      chk("t9_state_rst", bus0.state_dbg, 0);
      reset = 1'b0; op_out = 1'b0; cyc(1);
      chk_counts("t9");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Responder side of the CPU's IN/OUT/HALT handshake.
- The CPU raises op_in, op_out or op_halt and holds it. This block stalls the CPU, waits for an operator button press, then either:
  - supplies the switch value (IN), or
  - holds the CPU's output word on the display until it is acknowledged (OUT).
- Sits between the CPU and the switches, debounced button and seven-segment driver. It replaces clock-freezing with an explicit stall/valid/ack handshake on the slow system clock.

Parameters:
- DATA_WIDTH, 32, width of CPU data words.
- SWITCH_WIDTH, 18, number of input switches; must be ≤ DATA_WIDTH.
- SIGN_EXTEND, 0, 1 = sign-extend switches[SWITCH_WIDTH-1] into in_data, 0 = zero-extend.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op_in  input  1  CPU requests an input word; held until the request is released.
- op_out  input  1  CPU requests output of cpu_data; held until released.
- op_halt  input  1  CPU executed HALT.
- cpu_data  input  DATA_WIDTH  word to display, sampled on OUT acceptance.
- switches  input  SWITCH_WIDTH  operator input value.
- button  input  1  debounced level of the confirm button.
- in_data  output  DATA_WIDTH  registered extended switch value.
- in_valid  output  1  one-cycle strobe; in_data is valid.
- out_ack  output  1  one-cycle strobe; operator confirmed the displayed output.
- display_value  output  DATA_WIDTH  registered word for the display driver.
- display_valid  output  1  high while display_value must be shown; low means blank.
- cpu_stall  output  1  CPU must not advance.
- halted  output  1  halt state reached.
- protocol_error  output  1  sticky; more than one op_* was high at acceptance.
- state_dbg  output  3  current state encoding, for LEDs.

Behaviour:
- Reset (synchronous, priority over all else):
  - state = IDLE.
  - in_data = 0, in_valid = 0, out_ack = 0.
  - display_value = 0, display_valid = 0.
  - halted = 0, protocol_error = 0.
  - button_q (edge register) = 0.
- Button edge:
  - press = button & ~button_q.
  - button_q <= button every cycle.
  - A button already high on entry to a wait state does not count; a new rising edge is required.
- States and encodings: IDLE=0, WAIT_IN=1, IN_DONE=2, WAIT_OUT=3, OUT_DONE=4, HALTED=5.
- IDLE, priority op_halt > op_in > op_out:
  - op_halt → HALTED.
  - op_in → WAIT_IN.
  - op_out → display_value <= cpu_data, display_valid <= 1 → WAIT_OUT.
  - If two or more op_* are high in the same cycle, protocol_error <= 1; the priority choice still applies.
- WAIT_IN:
  - On press: in_data <= extended switches, in_valid = 1 for exactly the next cycle → IN_DONE.
  - If op_in drops before press (request aborted): → IDLE, no strobe.
- IN_DONE: stay until op_in = 0 → IDLE. This prevents a held op_in from generating a second transaction. in_data holds its value.
- WAIT_OUT:
  - display_valid stays 1 and display_value is frozen, even if cpu_data changes.
  - On press: out_ack = 1 for the next cycle → OUT_DONE.
  - If op_out drops first: display_valid <= 0 → IDLE.
- OUT_DONE: display_valid stays 1 until op_out = 0; then display_valid <= 0 → IDLE.
- HALTED: absorbing until reset. halted = 1, cpu_stall = 1, display keeps its last state. op_in, op_out and button are ignored.
- cpu_stall (combinational):
  - 1 in WAIT_IN, WAIT_OUT and HALTED.
  - 1 in IDLE when any op_* is high.
  - 0 in IN_DONE and OUT_DONE, so the CPU can consume data and release the request.
- Latency:
  - Request accepted the cycle after assertion.
  - in_valid/out_ack one cycle after the press edge is seen.
  - Press is visible at most one cycle after button rises.
- Simultaneous events: a press in the same cycle as request assertion in IDLE is not consumed. The request enters its wait state and needs a later edge.
- Reset mid-transaction: returns to IDLE with outputs cleared per the reset values above. The CPU must re-issue its request.

Test Plan:
- Reset with button held high, switches=18'h3FFFF → all outputs 0, state_dbg=0; no in_valid until the button is released and pressed again.
- op_in=1, switches=18'h20005, SIGN_EXTEND=0, button press → in_valid single pulse, in_data=32'h00020005; cpu_stall falls in IN_DONE; state returns to 0 after op_in=0. Repeat with SIGN_EXTEND=1 → in_data=32'hFFFE0005.
- op_out=1, cpu_data=32'hDEADBEEF, then cpu_data changes to 0 before press → display_value stays DEADBEEF, display_valid=1; press → one out_ack; display_valid=0 the cycle after op_out drops.
- op_in and op_out high together in IDLE → WAIT_IN entered, protocol_error=1, and it stays 1 through later transactions until reset.
- op_halt=1 → halted=1, cpu_stall=1; later op_in and presses produce no strobes; reset → IDLE.
- Button held high across the entire op_in request → no in_valid; op_in drop → IDLE with no strobe.
